// File: rtl/gray_input_sampler.sv
// Synchronises and debounces an asynchronous Gray-code bus, strobing each accepted word
// and flagging transitions that flip more than one bit. Define GRAY_ERR_COUNT_EN to add err_count.
module gray_input_sampler #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] gray_q,
    output logic             primed,
    output logic             new_pulse,
    output logic             err_multi,
    output logic             err_sticky
`ifdef GRAY_ERR_COUNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s1, s2, cand;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             multi;

    // A word equal to the one already presented is never re-accepted once primed.
    assign accept = (s2 == cand) && (cnt == CNT_MAX) && ((cand != gray_q) || !primed);
    assign multi  = accept && primed && ($countones(cand ^ gray_q) > 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1         <= '0;
            s2         <= '0;
            cand       <= '0;
            cnt        <= '0;
            gray_q     <= '0;
            primed     <= 1'b0;
            new_pulse  <= 1'b0;
            err_multi  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            s1 <= gray_in;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                gray_q <= cand;
                primed <= 1'b1;
            end
            new_pulse  <= accept;
            err_multi  <= multi;
            // A fresh error wins over a simultaneous clear.
            err_sticky <= (err_sticky & ~clr_err) | multi;
        end
    end

`ifdef GRAY_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (clr_err) begin
            err_count <= {7'd0, multi};
        end else if (multi && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
